// File: rtl/rvv_backend_pmtrdt_rs_pkg.sv
// Shared types and sizing for the PMTRDT reservation station.
// The uop payload is opaque to the station; only its width matters here.
package rvv_backend_pmtrdt_rs_pkg;

  localparam int NUM_PMTRDT      = 2;
  localparam int PMTRDT_RS_DEPTH = 8;

  typedef struct packed {
    logic [5:0]  uop_funct6;
    logic [2:0]  vxrm;
    logic [4:0]  vd_index;
    logic [3:0]  rob_entry;
    logic [13:0] vs_data;
  } PMT_RDT_RS_t;

endpackage

// File: rtl/rvv_backend_rs_ptr_add.sv
// Modular pointer + offset for a ring of DEPTH slots; DEPTH need not be a power of two.
// The offset must not exceed DEPTH, so a single conditional subtract is enough to wrap.
module rvv_backend_rs_ptr_add #(
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int OW    = 4
) (
  input  logic [PW-1:0] ptr_i,
  input  logic [OW-1:0] offset_i,
  output logic [PW-1:0] ptr_o
);

  localparam int SW = ((PW > OW) ? PW : OW) + 1;

  logic [SW-1:0] sum;

  always_comb begin
    sum   = SW'(ptr_i) + SW'(offset_i);
    ptr_o = PW'((sum >= SW'(DEPTH)) ? (sum - SW'(DEPTH)) : sum);
  end

endmodule

// File: rtl/rvv_backend_pmtrdt_rs.sv
// PMTRDT reservation station: multi-push / multi-pop circular FIFO that exposes its
// oldest NUM_POP entries to the execution units plus an in-order snapshot of all slots.
module rvv_backend_pmtrdt_rs
  import rvv_backend_pmtrdt_rs_pkg::*;
#(
  parameter int DEPTH      = PMTRDT_RS_DEPTH,
  parameter int NUM_PUSH   = 2,
  parameter int NUM_POP    = NUM_PMTRDT,
  parameter bit DROP_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PUSH-1:0] push_dp2rs,
  input  PMT_RDT_RS_t         uop_dp2rs [NUM_PUSH],
  output logic                fifo_full_rs2dp,
  output logic [NUM_PUSH-1:1] fifo_almost_full_rs2dp,
  input  logic [NUM_POP-1:0]  pop_ex2rs,
  output PMT_RDT_RS_t         pmtrdt_uop_rs2ex [NUM_POP],
  output logic                fifo_empty_rs2ex,
  output logic [NUM_POP-1:1]  fifo_almost_empty_rs2ex,
  output PMT_RDT_RS_t         all_uop_data [DEPTH]
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  PMT_RDT_RS_t         mem_q [DEPTH];
  logic [PW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       free, npush, npop;
  logic [NUM_PUSH-1:0] push_acc;
  logic [NUM_POP-1:0]  pop_acc;
  logic                push_run, pop_run;
  logic [PW-1:0]       widx [NUM_PUSH];
  logic [PW-1:0]       ridx [DEPTH];

  // Push is limited by pre-pop free space and pop by pre-push occupancy: no bypass.
  always_comb begin
    // NOTE: every output of this block gets a default before any conditional use,
    // so no path can leave a value held and infer a latch.
    free     = CW'(DEPTH) - count_q;
    npush    = '0;
    npop     = '0;
    push_run = 1'b1;
    pop_run  = 1'b1;
    push_acc = '0;
    pop_acc  = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      push_acc[i] = push_run && push_dp2rs[i] && (free > CW'(i));
      push_run    = push_acc[i];
      npush       = npush + CW'(push_acc[i]);
    end
    for (int i = 0; i < NUM_POP; i++) begin
      pop_acc[i] = pop_run && pop_ex2rs[i] && (count_q > CW'(i));
      pop_run    = pop_acc[i];
      npop       = npop + CW'(pop_acc[i]);
    end
    count_d = count_q + npush - npop;
  end

  rvv_backend_rs_ptr_add #(.DEPTH(DEPTH), .PW(PW), .OW(CW)) u_wptr_add (
    .ptr_i(wptr_q), .offset_i(npush), .ptr_o(wptr_d)
  );

  rvv_backend_rs_ptr_add #(.DEPTH(DEPTH), .PW(PW), .OW(CW)) u_rptr_add (
    .ptr_i(rptr_q), .offset_i(npop), .ptr_o(rptr_d)
  );

  for (genvar i = 0; i < NUM_PUSH; i++) begin : g_widx
    rvv_backend_rs_ptr_add #(.DEPTH(DEPTH), .PW(PW), .OW(CW)) u_widx_add (
      .ptr_i(wptr_q), .offset_i(CW'(i)), .ptr_o(widx[i])
    );
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_ridx
    rvv_backend_rs_ptr_add #(.DEPTH(DEPTH), .PW(PW), .OW(CW)) u_ridx_add (
      .ptr_i(rptr_q), .offset_i(CW'(j)), .ptr_o(ridx[j])
    );
    assign all_uop_data[j] = mem_q[ridx[j]];
  end

  for (genvar i = 0; i < NUM_POP; i++) begin : g_rs2ex
    assign pmtrdt_uop_rs2ex[i] = mem_q[ridx[i]];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      // NOTE: storage is reset here only because consumers see all slots through
      // all_uop_data and expect zeros after reset; plain RAM would not be.
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_PUSH; i++) begin
        if (push_acc[i]) mem_q[widx[i]] <= uop_dp2rs[i];
      end
    end
  end

  assign fifo_full_rs2dp  = (count_q == CW'(DEPTH));
  assign fifo_empty_rs2ex = (count_q == '0);

  for (genvar i = 1; i < NUM_PUSH; i++) begin : g_afull
    assign fifo_almost_full_rs2dp[i] = (free <= CW'(i));
  end

  for (genvar i = 1; i < NUM_POP; i++) begin : g_aempty
    assign fifo_almost_empty_rs2ex[i] = (count_q <= CW'(i));
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  a_ptr_gap: assert property (@(posedge clk) disable iff (rst)
    ((int'(wptr_q) - int'(rptr_q) + DEPTH) % DEPTH) == (int'(count_q) % DEPTH));

  // Requests that are not a legal thermometer within the current limit are dropped.
  if (DROP_CHECK) begin : g_drop_chk
    a_push_drop: assert property (@(posedge clk) disable iff (rst)
      (push_dp2rs & ~push_acc) == '0);
    a_pop_drop: assert property (@(posedge clk) disable iff (rst)
      (pop_ex2rs & ~pop_acc) == '0);
  end

endmodule

// File: tb/tb_rvv_backend_pmtrdt_rs.sv
// Self-checking bench for rvv_backend_pmtrdt_rs: directed scenarios plus a randomized
// run, all compared against a queue-style model of the station.
module tb_rvv_backend_pmtrdt_rs;
  import rvv_backend_pmtrdt_rs_pkg::*;

  localparam int DEPTH = PMTRDT_RS_DEPTH;
  localparam int NPU   = 2;
  localparam int NPO   = NUM_PMTRDT;

  logic            clk = 1'b0;
  logic            rst;
  logic [NPU-1:0]  push_dp2rs;
  PMT_RDT_RS_t     uop_dp2rs [NPU];
  logic            fifo_full_rs2dp;
  logic [NPU-1:1]  fifo_almost_full_rs2dp;
  logic [NPO-1:0]  pop_ex2rs;
  PMT_RDT_RS_t     pmtrdt_uop_rs2ex [NPO];
  logic            fifo_empty_rs2ex;
  logic [NPO-1:1]  fifo_almost_empty_rs2ex;
  PMT_RDT_RS_t     all_uop_data [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: slot array, head index and occupancy, advanced with plain modular arithmetic.
  PMT_RDT_RS_t m_mem [DEPTH];
  int          m_head;
  int          m_cnt;

  PMT_RDT_RS_t a_uop, b_uop, c_uop, d_uop, y_uop, e_uop, f_uop, g_uop;
  PMT_RDT_RS_t p_uop [4];

  rvv_backend_pmtrdt_rs #(
    .DEPTH(DEPTH), .NUM_PUSH(NPU), .NUM_POP(NPO), .DROP_CHECK(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_dp2rs(push_dp2rs),
    .uop_dp2rs(uop_dp2rs),
    .fifo_full_rs2dp(fifo_full_rs2dp),
    .fifo_almost_full_rs2dp(fifo_almost_full_rs2dp),
    .pop_ex2rs(pop_ex2rs),
    .pmtrdt_uop_rs2ex(pmtrdt_uop_rs2ex),
    .fifo_empty_rs2ex(fifo_empty_rs2ex),
    .fifo_almost_empty_rs2ex(fifo_almost_empty_rs2ex),
    .all_uop_data(all_uop_data)
  );

  always #5 clk = ~clk;

  function automatic PMT_RDT_RS_t rnd_uop();
    return PMT_RDT_RS_t'($urandom | 32'h1);
  endfunction

  task automatic model_step(input logic r, input logic [NPU-1:0] push,
                            input PMT_RDT_RS_t u0, input PMT_RDT_RS_t u1,
                            input logic [NPO-1:0] pop);
    int np, nq;
    if (r) begin
      for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
      m_head = 0;
      m_cnt  = 0;
      return;
    end
    np = 0;
    while (np < NPU && push[np] && np < DEPTH - m_cnt) np++;
    for (int k = 0; k < np; k++) m_mem[(m_head + m_cnt + k) % DEPTH] = (k == 0) ? u0 : u1;
    nq = 0;
    while (nq < NPO && pop[nq] && nq < m_cnt) nq++;
    m_head = (m_head + nq) % DEPTH;
    m_cnt  = m_cnt + np - nq;
  endtask

  // Drives one cycle from a negedge, updates the model at the posedge, returns at the next negedge.
  task automatic drive(input logic r, input logic [NPU-1:0] push,
                       input PMT_RDT_RS_t u0, input PMT_RDT_RS_t u1,
                       input logic [NPO-1:0] pop);
    rst          = r;
    push_dp2rs   = push;
    uop_dp2rs[0] = u0;
    uop_dp2rs[1] = u1;
    pop_ex2rs    = pop;
    @(posedge clk);
    model_step(r, push, u0, u1, pop);
    @(negedge clk);
    rst        = 1'b0;
    push_dp2rs = '0;
    pop_ex2rs  = '0;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, rnd_uop(), rnd_uop(), 2'b11);
    for (int k = 0; k < 3; k++) drive(1'b0, 2'b00, '0, '0, 2'b00);
    n_checks++;
    if (fifo_empty_rs2ex !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", fifo_empty_rs2ex);
    else n_pass++;
    n_checks++;
    if (fifo_almost_empty_rs2ex[1] !== 1'b1) $display("FAIL reset_aempty got=%0b exp=1", fifo_almost_empty_rs2ex[1]);
    else n_pass++;
    n_checks++;
    if (fifo_full_rs2dp !== 1'b0) $display("FAIL reset_full got=%0b exp=0", fifo_full_rs2dp);
    else n_pass++;
    n_checks++;
    if (fifo_almost_full_rs2dp[1] !== 1'b0) $display("FAIL reset_afull got=%0b exp=0", fifo_almost_full_rs2dp[1]);
    else n_pass++;
    for (int i = 0; i < NPO; i++) begin
      n_checks++;
      if (pmtrdt_uop_rs2ex[i] !== '0) $display("FAIL reset_rs2ex[%0d] got=%h exp=0", i, pmtrdt_uop_rs2ex[i]);
      else n_pass++;
    end
    for (int j = 0; j < DEPTH; j++) begin
      n_checks++;
      if (all_uop_data[j] !== '0) $display("FAIL reset_all[%0d] got=%h exp=0", j, all_uop_data[j]);
      else n_pass++;
    end
  endtask

  task automatic test_push_pair();
    a_uop = rnd_uop();
    b_uop = rnd_uop();
    drive(1'b0, 2'b11, a_uop, b_uop, 2'b00);
    n_checks++;
    if (fifo_empty_rs2ex !== 1'b0) $display("FAIL pair_empty got=%0b exp=0", fifo_empty_rs2ex);
    else n_pass++;
    n_checks++;
    if (fifo_almost_empty_rs2ex[1] !== 1'b0) $display("FAIL pair_aempty got=%0b exp=0", fifo_almost_empty_rs2ex[1]);
    else n_pass++;
    n_checks++;
    if (pmtrdt_uop_rs2ex[0] !== a_uop) $display("FAIL pair_rs2ex0 got=%h exp=%h", pmtrdt_uop_rs2ex[0], a_uop);
    else n_pass++;
    n_checks++;
    if (pmtrdt_uop_rs2ex[1] !== b_uop) $display("FAIL pair_rs2ex1 got=%h exp=%h", pmtrdt_uop_rs2ex[1], b_uop);
    else n_pass++;
    n_checks++;
    if (all_uop_data[0] !== a_uop) $display("FAIL pair_all0 got=%h exp=%h", all_uop_data[0], a_uop);
    else n_pass++;
    n_checks++;
    if (all_uop_data[1] !== b_uop) $display("FAIL pair_all1 got=%h exp=%h", all_uop_data[1], b_uop);
    else n_pass++;
  endtask

  task automatic test_fill_full();
    drive(1'b0, 2'b11, rnd_uop(), rnd_uop(), 2'b00);
    drive(1'b0, 2'b11, rnd_uop(), rnd_uop(), 2'b00);
    drive(1'b0, 2'b01, rnd_uop(), '0, 2'b00);
    n_checks++;
    if (fifo_almost_full_rs2dp[1] !== 1'b1) $display("FAIL fill7_afull got=%0b exp=1", fifo_almost_full_rs2dp[1]);
    else n_pass++;
    n_checks++;
    if (fifo_full_rs2dp !== 1'b0) $display("FAIL fill7_full got=%0b exp=0", fifo_full_rs2dp);
    else n_pass++;
    c_uop = rnd_uop();
    d_uop = rnd_uop();
    drive(1'b0, 2'b11, c_uop, d_uop, 2'b00);
    n_checks++;
    if (fifo_full_rs2dp !== 1'b1) $display("FAIL fill8_full got=%0b exp=1", fifo_full_rs2dp);
    else n_pass++;
    n_checks++;
    if (all_uop_data[7] !== c_uop) $display("FAIL fill8_last got=%h exp=%h", all_uop_data[7], c_uop);
    else n_pass++;
    n_checks++;
    if (all_uop_data[0] !== a_uop) $display("FAIL fill8_head got=%h exp=%h", all_uop_data[0], a_uop);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) drive(1'b0, 2'b00, '0, '0, 2'b11);
    drive(1'b0, 2'b00, '0, '0, 2'b01);
    y_uop = rnd_uop();
    drive(1'b0, 2'b01, y_uop, '0, 2'b00);
    n_checks++;
    if (pmtrdt_uop_rs2ex[0] !== c_uop) $display("FAIL wrap_rs2ex0 got=%h exp=%h", pmtrdt_uop_rs2ex[0], c_uop);
    else n_pass++;
    n_checks++;
    if (pmtrdt_uop_rs2ex[1] !== y_uop) $display("FAIL wrap_rs2ex1 got=%h exp=%h", pmtrdt_uop_rs2ex[1], y_uop);
    else n_pass++;
    drive(1'b0, 2'b00, '0, '0, 2'b11);
    n_checks++;
    if (fifo_empty_rs2ex !== 1'b1) $display("FAIL wrap_empty got=%0b exp=1", fifo_empty_rs2ex);
    else n_pass++;
    // Head now sits on slot 1, which still holds the second uop of the first pair.
    n_checks++;
    if (pmtrdt_uop_rs2ex[0] !== b_uop) $display("FAIL wrap_head got=%h exp=%h", pmtrdt_uop_rs2ex[0], b_uop);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) p_uop[k] = rnd_uop();
    drive(1'b0, 2'b11, p_uop[0], p_uop[1], 2'b00);
    drive(1'b0, 2'b11, p_uop[2], p_uop[3], 2'b00);
    e_uop = rnd_uop();
    f_uop = rnd_uop();
    drive(1'b0, 2'b11, e_uop, f_uop, 2'b11);
    n_checks++;
    if (all_uop_data[0] !== p_uop[2] || all_uop_data[1] !== p_uop[3])
      $display("FAIL b2b_head got=%h,%h exp=%h,%h", all_uop_data[0], all_uop_data[1], p_uop[2], p_uop[3]);
    else n_pass++;
    n_checks++;
    if (all_uop_data[2] !== e_uop || all_uop_data[3] !== f_uop)
      $display("FAIL b2b_new got=%h,%h exp=%h,%h", all_uop_data[2], all_uop_data[3], e_uop, f_uop);
    else n_pass++;
    n_checks++;
    if (fifo_full_rs2dp !== 1'b0 || fifo_almost_full_rs2dp[1] !== 1'b0 || fifo_empty_rs2ex !== 1'b0)
      $display("FAIL b2b_flags got=%0b%0b%0b exp=000", fifo_full_rs2dp, fifo_almost_full_rs2dp[1], fifo_empty_rs2ex);
    else n_pass++;
    drive(1'b0, 2'b11, rnd_uop(), rnd_uop(), 2'b00);
    drive(1'b0, 2'b11, rnd_uop(), rnd_uop(), 2'b00);
    n_checks++;
    if (fifo_full_rs2dp !== 1'b1) $display("FAIL b2b_full got=%0b exp=1", fifo_full_rs2dp);
    else n_pass++;
    g_uop = rnd_uop();
    drive(1'b0, 2'b01, g_uop, '0, 2'b01);
    n_checks++;
    if (fifo_full_rs2dp !== 1'b0 || fifo_almost_full_rs2dp[1] !== 1'b1)
      $display("FAIL fullpop_flags got=%0b%0b exp=01", fifo_full_rs2dp, fifo_almost_full_rs2dp[1]);
    else n_pass++;
    // The slot just vacated must still hold the popped uop, not the rejected push.
    n_checks++;
    if (all_uop_data[7] !== p_uop[2]) $display("FAIL fullpop_stale got=%h exp=%h", all_uop_data[7], p_uop[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'b00, '0, '0, 2'b11);
    n_checks++;
    if (fifo_empty_rs2ex !== 1'b0) $display("FAIL mid_pre_empty got=%0b exp=0", fifo_empty_rs2ex);
    else n_pass++;
    drive(1'b1, 2'b11, rnd_uop(), rnd_uop(), 2'b11);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (fifo_empty_rs2ex !== 1'b1 || fifo_full_rs2dp !== 1'b0 || fifo_almost_empty_rs2ex[1] !== 1'b1)
        $display("FAIL mid_flags[%0d] got=%0b%0b%0b exp=101", k, fifo_empty_rs2ex, fifo_full_rs2dp, fifo_almost_empty_rs2ex[1]);
      else n_pass++;
      for (int j = 0; j < DEPTH; j++) begin
        n_checks++;
        if (all_uop_data[j] !== '0) $display("FAIL mid_all[%0d] got=%h exp=0", j, all_uop_data[j]);
        else n_pass++;
      end
      n_checks++;
      if (pmtrdt_uop_rs2ex[0] !== '0 || pmtrdt_uop_rs2ex[1] !== '0)
        $display("FAIL mid_rs2ex got=%h,%h exp=0,0", pmtrdt_uop_rs2ex[0], pmtrdt_uop_rs2ex[1]);
      else n_pass++;
      drive(1'b0, 2'b00, '0, '0, 2'b00);
    end
  endtask

  task automatic test_random();
    logic [NPU-1:0] push;
    logic [NPO-1:0] pop;
    bit             exp_bit;
    for (int c = 0; c < 400; c++) begin
      push = NPU'($urandom_range(0, 3));
      pop  = NPO'($urandom_range(0, 3));
      if (((c / 40) % 2) == 0 && $urandom_range(0, 1) == 1) pop = '0;
      if (((c / 40) % 2) == 1 && $urandom_range(0, 1) == 1) push = '0;
      drive(1'b0, push, rnd_uop(), rnd_uop(), pop);
      n_checks++;
      if (fifo_full_rs2dp !== (m_cnt == DEPTH) || fifo_empty_rs2ex !== (m_cnt == 0))
        $display("FAIL rnd_fe[%0d] full=%0b empty=%0b model_count=%0d", c, fifo_full_rs2dp, fifo_empty_rs2ex, m_cnt);
      else n_pass++;
      for (int i = 1; i < NPU; i++) begin
        exp_bit = ((DEPTH - m_cnt) <= i);
        n_checks++;
        if (fifo_almost_full_rs2dp[i] !== exp_bit)
          $display("FAIL rnd_afull[%0d][%0d] got=%0b exp=%0b", c, i, fifo_almost_full_rs2dp[i], exp_bit);
        else n_pass++;
      end
      for (int i = 1; i < NPO; i++) begin
        exp_bit = (m_cnt <= i);
        n_checks++;
        if (fifo_almost_empty_rs2ex[i] !== exp_bit)
          $display("FAIL rnd_aempty[%0d][%0d] got=%0b exp=%0b", c, i, fifo_almost_empty_rs2ex[i], exp_bit);
        else n_pass++;
      end
      for (int i = 0; i < NPO; i++) begin
        n_checks++;
        if (pmtrdt_uop_rs2ex[i] !== m_mem[(m_head + i) % DEPTH])
          $display("FAIL rnd_rs2ex[%0d][%0d] got=%h exp=%h", c, i, pmtrdt_uop_rs2ex[i], m_mem[(m_head + i) % DEPTH]);
        else n_pass++;
      end
      for (int j = 0; j < DEPTH; j++) begin
        n_checks++;
        if (all_uop_data[j] !== m_mem[(m_head + j) % DEPTH])
          $display("FAIL rnd_all[%0d][%0d] got=%h exp=%h", c, j, all_uop_data[j], m_mem[(m_head + j) % DEPTH]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    push_dp2rs   = '0;
    pop_ex2rs    = '0;
    uop_dp2rs[0] = '0;
    uop_dp2rs[1] = '0;
    m_head       = 0;
    m_cnt        = 0;
    for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
    @(negedge clk);
    test_reset();
    test_push_pair();
    test_fill_full();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
